// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction cache (port 0) and data cache (port 1) share one memory.
// Non-preemptive grants with round-robin tie-break and saturating per-port completion counters.
module mem_arbiter #(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_p0_cen,
    input  logic                 i_p0_wen,
    input  logic [ADDR_W-1:0]    i_p0_addr,
    input  logic [BIT_W*4-1:0]   i_p0_wdata,
    output logic [BIT_W*4-1:0]   o_p0_rdata,
    output logic                 o_p0_stall,
    input  logic                 i_p1_cen,
    input  logic                 i_p1_wen,
    input  logic [ADDR_W-1:0]    i_p1_addr,
    input  logic [BIT_W*4-1:0]   i_p1_wdata,
    output logic [BIT_W*4-1:0]   o_p1_rdata,
    output logic                 o_p1_stall,
    output logic                 o_mem_cen,
    output logic                 o_mem_wen,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [BIT_W*4-1:0]   o_mem_wdata,
    input  logic [BIT_W*4-1:0]   i_mem_rdata,
    input  logic                 i_mem_stall,
    output logic                 o_busy,
    output logic [15:0]          o_p0_grants,
    output logic [15:0]          o_p1_grants
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic [15:0] p0_grants_q, p0_grants_d;
    logic [15:0] p1_grants_q, p1_grants_d;

    logic gnt0, gnt1;
    assign gnt0 = (state_q == GRANT0);
    assign gnt1 = (state_q == GRANT1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        p0_grants_d = p0_grants_q;
        p1_grants_d = p1_grants_q;
        case (state_q)
            IDLE: begin
                if (i_p0_cen && i_p1_cen) begin
                    // Tie goes to the port that was not served last.
                    state_d = last_gnt_q ? GRANT0 : GRANT1;
                end else if (i_p0_cen) begin
                    state_d = GRANT0;
                end else if (i_p1_cen) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!i_p0_cen) begin
                    state_d = IDLE;
                end else if (!i_mem_stall) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                    if (p0_grants_q != 16'hFFFF) p0_grants_d = p0_grants_q + 16'd1;
                end
            end
            GRANT1: begin
                if (!i_p1_cen) begin
                    state_d = IDLE;
                end else if (!i_mem_stall) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                    if (p1_grants_q != 16'hFFFF) p1_grants_d = p1_grants_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is sequential, so it is updated with non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            p0_grants_q <= 16'd0;
            p1_grants_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            p0_grants_q <= p0_grants_d;
            p1_grants_q <= p1_grants_d;
        end
    end

    // Memory side is a straight mux of the granted port; zero while idle.
    always_comb begin
        o_mem_cen   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (gnt0) begin
            o_mem_cen   = i_p0_cen;
            o_mem_wen   = i_p0_wen;
            o_mem_addr  = i_p0_addr;
            o_mem_wdata = i_p0_wdata;
        end else if (gnt1) begin
            o_mem_cen   = i_p1_cen;
            o_mem_wen   = i_p1_wen;
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
        end
    end

    assign o_p0_stall  = i_p0_cen & ~(gnt0 & ~i_mem_stall);
    assign o_p1_stall  = i_p1_cen & ~(gnt1 & ~i_mem_stall);
    assign o_p0_rdata  = gnt0 ? i_mem_rdata : '0;
    assign o_p1_rdata  = gnt1 ? i_mem_rdata : '0;
    assign o_busy      = (state_q != IDLE);
    assign o_p0_grants = p0_grants_q;
    assign o_p1_grants = p1_grants_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked against
// a transaction-level model of who owns the memory and how many transfers each port finished.
module tb_mem_arbiter;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_p0_cen, i_p0_wen, i_p1_cen, i_p1_wen;
    logic [ADDR_W-1:0] i_p0_addr, i_p1_addr;
    logic [LINE_W-1:0] i_p0_wdata, i_p1_wdata;
    logic [LINE_W-1:0] o_p0_rdata, o_p1_rdata;
    logic              o_p0_stall, o_p1_stall;
    logic              o_mem_cen, o_mem_wen;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [LINE_W-1:0] o_mem_wdata;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_stall;
    logic              o_busy;
    logic [15:0]       o_p0_grants, o_p1_grants;

    mem_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_p0_cen(i_p0_cen), .i_p0_wen(i_p0_wen), .i_p0_addr(i_p0_addr),
        .i_p0_wdata(i_p0_wdata), .o_p0_rdata(o_p0_rdata), .o_p0_stall(o_p0_stall),
        .i_p1_cen(i_p1_cen), .i_p1_wen(i_p1_wen), .i_p1_addr(i_p1_addr),
        .i_p1_wdata(i_p1_wdata), .o_p1_rdata(o_p1_rdata), .o_p1_stall(o_p1_stall),
        .o_mem_cen(o_mem_cen), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_stall(i_mem_stall),
        .o_busy(o_busy), .o_p0_grants(o_p0_grants), .o_p1_grants(o_p1_grants)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: owner of the memory (-1 none), port served last, completed transfers per port.
    int owner;
    int last_served;
    int done0, done1;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner       = -1;
        last_served = 1;
        done0       = 0;
        done1       = 0;
    endtask

    // One rising edge of the arbitration rules, computed from the current inputs.
    task automatic model_step();
        logic wants;
        if (owner < 0) begin
            if (i_p0_cen && i_p1_cen) owner = 1 - last_served;
            else if (i_p0_cen)        owner = 0;
            else if (i_p1_cen)        owner = 1;
        end else begin
            wants = (owner == 0) ? i_p0_cen : i_p1_cen;
            if (!wants) begin
                owner = -1;
            end else if (!i_mem_stall) begin
                last_served = owner;
                if (owner == 0) done0 = (done0 < 65535) ? done0 + 1 : 65535;
                else            done1 = (done1 < 65535) ? done1 + 1 : 65535;
                owner = -1;
            end
        end
    endtask

    task automatic check_outputs();
        logic              e_cen, e_wen;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_wdata;
        e_cen = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
        if (owner == 0) begin
            e_cen = i_p0_cen; e_wen = i_p0_wen; e_addr = i_p0_addr; e_wdata = i_p0_wdata;
        end else if (owner == 1) begin
            e_cen = i_p1_cen; e_wen = i_p1_wen; e_addr = i_p1_addr; e_wdata = i_p1_wdata;
        end
        check("mem_cen",   LINE_W'(o_mem_cen),   LINE_W'(e_cen));
        check("mem_wen",   LINE_W'(o_mem_wen),   LINE_W'(e_wen));
        check("mem_addr",  LINE_W'(o_mem_addr),  LINE_W'(e_addr));
        check("mem_wdata", o_mem_wdata,          e_wdata);
        check("p0_stall",  LINE_W'(o_p0_stall),  LINE_W'(i_p0_cen && !(owner == 0 && !i_mem_stall)));
        check("p1_stall",  LINE_W'(o_p1_stall),  LINE_W'(i_p1_cen && !(owner == 1 && !i_mem_stall)));
        check("p0_rdata",  o_p0_rdata,           (owner == 0) ? i_mem_rdata : '0);
        check("p1_rdata",  o_p1_rdata,           (owner == 1) ? i_mem_rdata : '0);
        check("busy",      LINE_W'(o_busy),      LINE_W'(owner >= 0));
        check("p0_grants", LINE_W'(o_p0_grants), LINE_W'(done0));
        check("p1_grants", LINE_W'(o_p1_grants), LINE_W'(done1));
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        #1;
        if (i_rst) model_reset();
        check_outputs();
        @(posedge i_clk);
        if (!i_rst) model_step();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_p0_cen = 1'b0; i_p0_wen = 1'b0; i_p0_addr = '0; i_p0_wdata = '0;
        i_p1_cen = 1'b0; i_p1_wen = 1'b0; i_p1_addr = '0; i_p1_wdata = '0;
        i_mem_stall = 1'b0; i_mem_rdata = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    int stall_cycles;

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge i_clk);
        do_reset();

        // Single read with three memory stall cycles.
        i_p0_cen = 1'b1; i_p0_addr = 32'h1000; i_mem_stall = 1'b1;
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (o_p0_stall) stall_cycles++;
            if (i >= 1) check("read_addr", LINE_W'(o_mem_addr), LINE_W'(32'h1000));
            tick();
        end
        i_mem_stall = 1'b0; i_mem_rdata = {16{8'hA5}};
        #1 check("read_rdata", o_p0_rdata, {16{8'hA5}});
        check("read_done_stall", LINE_W'(o_p0_stall), '0);
        tick();
        check("read_stall_cycles", LINE_W'(stall_cycles), LINE_W'(4));
        check("read_grants", LINE_W'(o_p0_grants), LINE_W'(1));
        idle_inputs();
        tick();

        // Simultaneous requests straight after reset: p0 first, then p1's write.
        do_reset();
        i_p0_cen = 1'b1; i_p0_addr = 32'h100;
        i_p1_cen = 1'b1; i_p1_wen = 1'b1; i_p1_addr = 32'h200; i_p1_wdata = {4{32'hCAFE_F00D}};
        tick();
        #1 check("both_first_addr", LINE_W'(o_mem_addr), LINE_W'(32'h100));
        check("both_first_wen", LINE_W'(o_mem_wen), '0);
        tick();
        i_p0_cen = 1'b0;
        tick();
        #1 check("both_second_addr", LINE_W'(o_mem_addr), LINE_W'(32'h200));
        check("both_second_wen", LINE_W'(o_mem_wen), LINE_W'(1));
        tick();
        idle_inputs();
        tick();

        // Fairness: continuous requests from both ports for ten transfers.
        do_reset();
        i_p0_cen = 1'b1; i_p0_addr = 32'hA0;
        i_p1_cen = 1'b1; i_p1_addr = 32'hB0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) begin
                #1 check("fair_order", LINE_W'(o_mem_addr), (i % 4 == 1) ? LINE_W'(32'hA0) : LINE_W'(32'hB0));
            end
            tick();
        end
        check("fair_p0", LINE_W'(o_p0_grants), LINE_W'(5));
        check("fair_p1", LINE_W'(o_p1_grants), LINE_W'(5));
        idle_inputs();
        tick();

        // Abort: p1 drops its request while the memory is stalled.
        i_p1_cen = 1'b1; i_p1_addr = 32'h300; i_mem_stall = 1'b1;
        tick();
        tick();
        i_p1_cen = 1'b0;
        tick();
        #1 check("abort_cen", LINE_W'(o_mem_cen), '0);
        check("abort_busy", LINE_W'(o_busy), '0);
        check("abort_grants", LINE_W'(o_p1_grants), LINE_W'(5));
        idle_inputs();
        tick();

        // Reset in the middle of a stalled GRANT0, asserted between clock edges.
        i_p0_cen = 1'b1; i_p0_addr = 32'h400; i_mem_stall = 1'b1;
        tick();
        tick();
        #2 i_rst = 1'b1;
        #1 check("rst_mid_cen", LINE_W'(o_mem_cen), '0);
        check("rst_mid_busy", LINE_W'(o_busy), '0);
        check("rst_mid_p0_grants", LINE_W'(o_p0_grants), '0);
        model_reset();
        @(negedge i_clk);
        tick();
        i_rst = 1'b0;
        i_p1_cen = 1'b1; i_p1_addr = 32'h500; i_mem_stall = 1'b0;
        tick();
        #1 check("rst_tie_winner", LINE_W'(o_mem_addr), LINE_W'(32'h400));
        idle_inputs();
        tick();
        tick();

        // Saturation: start p0's counter at 0xFFFE and finish three more transfers.
        do_reset();
        force dut.p0_grants_q = 16'hFFFE;
        done0 = 16'hFFFE;
        tick();
        release dut.p0_grants_q;
        i_p0_cen = 1'b1; i_p0_addr = 32'h600;
        for (int i = 0; i < 6; i++) tick();
        check("sat_p0", LINE_W'(o_p0_grants), LINE_W'(16'hFFFF));
        idle_inputs();
        tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            i_rst       = ($urandom_range(0, 99) == 0);
            i_p0_cen    = ($urandom_range(0, 9) < 7);
            i_p1_cen    = ($urandom_range(0, 9) < 7);
            i_p0_wen    = $urandom_range(0, 1) == 1;
            i_p1_wen    = $urandom_range(0, 1) == 1;
            i_p0_addr   = $urandom;
            i_p1_addr   = $urandom;
            i_p0_wdata  = {$urandom, $urandom, $urandom, $urandom};
            i_p1_wdata  = {$urandom, $urandom, $urandom, $urandom};
            i_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            i_mem_stall = $urandom_range(0, 1) == 1;
            tick();
        end
        i_rst = 1'b0;
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
